// File: rtl/ssp_pkg.sv
// Shared types and constants for the SSP transmit sequencer.
package ssp_pkg;

    // Default serial word width (bits per frame).
    localparam int SSP_DATA_W = 8;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRAME = 2'd1,
        SHIFT = 2'd2
    } ssp_state_e;

    // Width of the half-period counter; at least one bit even when HALF_PERIOD is 1.
    function automatic int ssp_cnt_w(input int halfPeriod);
        return (halfPeriod > 1) ? $clog2(halfPeriod) : 1;
    endfunction

endpackage

// File: rtl/ssp_clk_gen.sv
// Serial clock divider: toggles sspclkout every HALF_PERIOD pclk cycles and
// flags the pclk cycle that ends with sspclkout going from 0 to 1.
module ssp_clk_gen
    import ssp_pkg::*;
#(
    parameter int HALF_PERIOD = 1
) (
    input  logic pclk,
    input  logic clear,
    output logic sspclkout,
    output logic rise
);

    localparam int CNT_W = ssp_cnt_w(HALF_PERIOD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_PERIOD - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_clk;
    logic             w_wrap;

    assign w_wrap    = (r_cnt == CNT_LAST);
    assign rise      = w_wrap & ~r_clk;
    assign sspclkout = r_clk;

    // Half-period counter; the serial clock flips each time the counter wraps.
    always_ff @(posedge pclk) begin
        if (clear) begin
            r_cnt <= '0;
            r_clk <= 1'b0;
        end else if (w_wrap) begin
            r_cnt <= '0;
            r_clk <= ~r_clk;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ssp_tx_ctrl.sv
// SSP transmit sequencer: pops one word per frame from the transmit FIFO,
// sends a one-period frame sync, then shifts the word out MSB first. All
// serial outputs change only on pclk cycles that produce a serial clock rise.
module ssp_tx_ctrl
    import ssp_pkg::*;
#(
    parameter int DATA_W      = SSP_DATA_W,
    parameter int HALF_PERIOD = 1
) (
    input  logic              pclk,
    input  logic              clear,
    input  logic              en,
    input  logic              tmit,
    input  logic [DATA_W-1:0] txdata,
    output logic              remove,
    output logic              sspclkout,
    output logic              sspfssout,
    output logic              ssptxd,
    output logic              sspoe_b,
    output logic              busy
);

    localparam int BC_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_W - 1);

    ssp_state_e        r_state;
    logic [DATA_W-1:0] r_shift;
    logic [BC_W-1:0]   r_bitCnt;
    logic              r_remove;
    logic              r_fss;
    logic              r_txd;
    logic              r_oeB;
    logic              w_rise;
    logic              w_start;

    ssp_clk_gen #(
        .HALF_PERIOD(HALF_PERIOD)
    ) u_clk_gen (
        .pclk     (pclk),
        .clear    (clear),
        .sspclkout(sspclkout),
        .rise     (w_rise)
    );

    // A new frame may only begin when the FIFO has a word and transmit is enabled.
    assign w_start = tmit & en;

    assign remove    = r_remove;
    assign sspfssout = r_fss;
    assign ssptxd    = r_txd;
    assign sspoe_b   = r_oeB;
    assign busy      = (r_state != IDLE);

    // Frame sequencer; every transition happens on a serial clock rise, and the
    // pop strobe lasts exactly the one pclk following a load. Data is held low
    // during the frame-sync period, including on a back-to-back reload.
    always_ff @(posedge pclk) begin
        if (clear) begin
            r_state  <= IDLE;
            r_shift  <= '0;
            r_bitCnt <= '0;
            r_remove <= 1'b0;
            r_fss    <= 1'b0;
            r_txd    <= 1'b0;
            r_oeB    <= 1'b1;
        end else begin
            r_remove <= 1'b0;
            if (w_rise) begin
                case (r_state)
                    IDLE: begin
                        if (w_start) begin
                            r_shift  <= txdata;
                            r_remove <= 1'b1;
                            r_fss    <= 1'b1;
                            r_txd    <= 1'b0;
                            r_oeB    <= 1'b0;
                            r_state  <= FRAME;
                        end else begin
                            r_fss <= 1'b0;
                            r_txd <= 1'b0;
                            r_oeB <= 1'b1;
                        end
                    end
                    FRAME: begin
                        r_txd    <= r_shift[DATA_W-1];
                        r_shift  <= r_shift << 1;
                        r_fss    <= 1'b0;
                        r_bitCnt <= BC_LAST;
                        r_state  <= SHIFT;
                    end
                    SHIFT: begin
                        if (r_bitCnt != '0) begin
                            r_txd    <= r_shift[DATA_W-1];
                            r_shift  <= r_shift << 1;
                            r_bitCnt <= r_bitCnt - 1'b1;
                        end else if (w_start) begin
                            r_shift  <= txdata;
                            r_remove <= 1'b1;
                            r_fss    <= 1'b1;
                            r_txd    <= 1'b0;
                            r_oeB    <= 1'b0;
                            r_state  <= FRAME;
                        end else begin
                            r_txd   <= 1'b0;
                            r_oeB   <= 1'b1;
                            r_state <= IDLE;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ssp_tx_ctrl.sv
// Self-checking bench for ssp_tx_ctrl: one instance at HALF_PERIOD=1 and one
// at HALF_PERIOD=3, checked against a frame-timing model and a serial receiver.
module tb_ssp_tx_ctrl;

    localparam int W   = 8;
    localparam int HP1 = 1;
    localparam int HP3 = 3;
    localparam int FL1 = (W + 1) * 2 * HP1;
    localparam logic [4:0] IDLE_OUT = 5'b00010;

    logic pclk = 1'b0;
    always #5 pclk = ~pclk;

    logic         clear = 1'b1, en = 1'b1, tmit = 1'b0;
    logic [W-1:0] txdata = '0;
    logic         remove, sspclkout, sspfssout, ssptxd, sspoe_b, busy;

    logic         clear3 = 1'b1, en3 = 1'b1, tmit3 = 1'b0;
    logic [W-1:0] txdata3 = '0;
    logic         remove3, sspclkout3, sspfssout3, ssptxd3, sspoe_b3, busy3;

    int nChecks = 0;
    int nErrors = 0;

    ssp_tx_ctrl #(.DATA_W(W), .HALF_PERIOD(HP1)) dut1 (
        .pclk(pclk), .clear(clear), .en(en), .tmit(tmit), .txdata(txdata),
        .remove(remove), .sspclkout(sspclkout), .sspfssout(sspfssout),
        .ssptxd(ssptxd), .sspoe_b(sspoe_b), .busy(busy)
    );

    ssp_tx_ctrl #(.DATA_W(W), .HALF_PERIOD(HP3)) dut3 (
        .pclk(pclk), .clear(clear3), .en(en3), .tmit(tmit3), .txdata(txdata3),
        .remove(remove3), .sspclkout(sspclkout3), .sspfssout(sspfssout3),
        .ssptxd(ssptxd3), .sspoe_b(sspoe_b3), .busy(busy3)
    );

    // Expected {remove, sspfssout, ssptxd, sspoe_b, busy} at a pclk offset from
    // the cycle where a frame's remove pulse is seen.
    function automatic logic [4:0] expFrame(input int off, input logic [W-1:0] d, input int hp);
        int per;
        int fl;
        logic [W-1:0] sh;
        logic [4:0] r;
        per = 2 * hp;
        fl  = (W + 1) * per;
        if (off < 0 || off >= fl) return IDLE_OUT;
        r[4] = (off == 0);
        r[3] = (off < per);
        if (off < per) begin
            r[2] = 1'b0;
        end else begin
            sh   = d << (off / per - 1);
            r[2] = sh[W-1];
        end
        r[1] = 1'b0;
        r[0] = 1'b1;
        return r;
    endfunction

    // Monitor for dut1: serial clock waveform, remove rules, and a receiver
    // that samples on falling serial clock edges and scores popped words.
    int           cyc1 = 0;
    logic         expClk1;
    logic         prevClk1 = 1'b0, prevRem1 = 1'b0;
    logic         rxActive = 1'b0;
    int           rxN = 0;
    logic [W-1:0] rxWord = '0;
    logic [W-1:0] rxExp;
    logic [W-1:0] expQ[$];

    always @(posedge pclk) begin
        #1;
        if (clear) begin
            cyc1 = 0;
            rxActive = 1'b0;
            expQ.delete();
        end else begin
            cyc1++;
        end
        expClk1 = ((cyc1 / HP1) % 2) == 1;
        nChecks++;
        if (sspclkout !== expClk1) begin
            $display("[TB] FAIL clk1 cyc=%0d got=%b expected=%b", cyc1, sspclkout, expClk1);
            nErrors++;
        end
        if (!clear) begin
            if (remove === 1'b1) begin
                nChecks++;
                if (prevRem1 || tmit !== 1'b1) begin
                    $display("[TB] FAIL remove_rule prevRemove=%b tmit=%b expected 0/1", prevRem1, tmit);
                    nErrors++;
                end
                expQ.push_back(txdata);
            end
            if (prevClk1 && !sspclkout) begin
                if (sspfssout) begin
                    rxActive = 1'b1;
                    rxN = 0;
                end else if (rxActive) begin
                    rxWord = {rxWord[W-2:0], ssptxd};
                    rxN++;
                    if (rxN == W) begin
                        rxActive = 1'b0;
                        nChecks++;
                        if (expQ.size() == 0) begin
                            $display("[TB] FAIL rx_word got=%h expected none", rxWord);
                            nErrors++;
                        end else begin
                            rxExp = expQ.pop_front();
                            if (rxWord !== rxExp) begin
                                $display("[TB] FAIL rx_word got=%h expected=%h", rxWord, rxExp);
                                nErrors++;
                            end
                        end
                    end
                end
            end
        end
        prevClk1 = sspclkout;
        prevRem1 = remove;
    end

    // Monitor for dut3: serial clock waveform and no back-to-back pops.
    int   cyc3 = 0;
    logic expClk3;
    logic prevRem3 = 1'b0;

    always @(posedge pclk) begin
        #1;
        if (clear3) cyc3 = 0;
        else        cyc3++;
        expClk3 = ((cyc3 / HP3) % 2) == 1;
        nChecks++;
        if (sspclkout3 !== expClk3) begin
            $display("[TB] FAIL clk3 cyc=%0d got=%b expected=%b", cyc3, sspclkout3, expClk3);
            nErrors++;
        end
        if (remove3 === 1'b1 && prevRem3) begin
            nChecks++;
            $display("[TB] FAIL remove3_consecutive got=1 expected=0");
            nErrors++;
        end
        prevRem3 = remove3;
    end

    // Wait (bounded) for a remove pulse on the chosen instance.
    task automatic waitRemove(input bit sel3, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n < 16) begin
            @(negedge pclk);
            n++;
            if ((sel3 ? remove3 : remove) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Offer up to three words back-to-back on dut1 and check every pclk.
    task automatic runStream(input logic [W-1:0] d0, input logic [W-1:0] d1, input logic [W-1:0] d2,
                             input int nBytes, input int tail, input string name);
        logic [W-1:0] bytes[3];
        int n, popped, f;
        bit ok;
        logic [4:0] expV, gotV;
        bytes[0] = d0; bytes[1] = d1; bytes[2] = d2;
        txdata = bytes[0];
        tmit   = 1'b1;
        waitRemove(1'b0, n, ok);
        nChecks++;
        if (!ok || n > 2 * HP1) begin
            $display("[TB] FAIL %s_latency got=%0d expected<=%0d", name, n, 2 * HP1);
            nErrors++;
            if (!ok) begin
                tmit = 1'b0;
                return;
            end
        end
        popped = 0;
        for (int off = 0; off < nBytes * FL1 + tail; off++) begin
            if (off > 0) @(negedge pclk);
            f    = off / FL1;
            expV = (f < nBytes) ? expFrame(off - f * FL1, bytes[f], HP1) : IDLE_OUT;
            gotV = {remove, sspfssout, ssptxd, sspoe_b, busy};
            nChecks++;
            if (gotV !== expV) begin
                $display("[TB] FAIL %s off=%0d got=%b expected=%b", name, off, gotV, expV);
                nErrors++;
            end
            if (remove === 1'b1) begin
                popped++;
                if (popped < nBytes) txdata = bytes[popped];
                else                 tmit = 1'b0;
            end
        end
    endtask

    // Check a whole dut3 frame starting at the current (remove) cycle.
    task automatic checkFrame3(input logic [W-1:0] d, input int nCyc, input string name);
        logic [4:0] expV, gotV;
        for (int off = 0; off < nCyc; off++) begin
            if (off > 0) @(negedge pclk);
            expV = expFrame(off, d, HP3);
            gotV = {remove3, sspfssout3, ssptxd3, sspoe_b3, busy3};
            nChecks++;
            if (gotV !== expV) begin
                $display("[TB] FAIL %s off=%0d got=%b expected=%b", name, off, gotV, expV);
                nErrors++;
            end
            if (off == 0) tmit3 = 1'b0;
        end
    endtask

    task automatic test_reset();
        repeat (3) begin
            @(negedge pclk);
            nChecks++;
            if ({remove, sspfssout, ssptxd, sspoe_b, busy, sspclkout} !== 6'b000100) begin
                $display("[TB] FAIL reset1 got=%b expected=000100",
                         {remove, sspfssout, ssptxd, sspoe_b, busy, sspclkout});
                nErrors++;
            end
            nChecks++;
            if ({remove3, sspfssout3, ssptxd3, sspoe_b3, busy3, sspclkout3} !== 6'b000100) begin
                $display("[TB] FAIL reset3 got=%b expected=000100",
                         {remove3, sspfssout3, ssptxd3, sspoe_b3, busy3, sspclkout3});
                nErrors++;
            end
        end
        clear  = 1'b0;
        clear3 = 1'b0;
        repeat (4) @(negedge pclk);
        nChecks++;
        if ({sspoe_b, busy} !== 2'b10) begin
            $display("[TB] FAIL idle_after_reset got=%b expected=10", {sspoe_b, busy});
            nErrors++;
        end
    endtask

    task automatic test_single();
        runStream(8'hA5, 8'h00, 8'h00, 1, 6, "single");
    endtask

    task automatic test_back_to_back();
        runStream(8'h81, 8'h7E, 8'h00, 2, 6, "b2b");
    endtask

    task automatic test_enable_gating();
        int n;
        bit ok;
        logic [4:0] expV, gotV;
        txdata = 8'h3C;
        en     = 1'b1;
        tmit   = 1'b1;
        waitRemove(1'b0, n, ok);
        nChecks++;
        if (!ok) begin
            $display("[TB] FAIL engate_start got=timeout expected=remove");
            nErrors++;
            tmit = 1'b0;
            return;
        end
        for (int off = 0; off < 28; off++) begin
            if (off > 0) @(negedge pclk);
            if (off < FL1)       expV = expFrame(off, 8'h3C, HP1);
            else if (off >= 26)  expV = expFrame(off - 26, 8'h3C, HP1);
            else                 expV = IDLE_OUT;
            gotV = {remove, sspfssout, ssptxd, sspoe_b, busy};
            nChecks++;
            if (gotV !== expV) begin
                $display("[TB] FAIL engate off=%0d got=%b expected=%b", off, gotV, expV);
                nErrors++;
            end
            if (off == 9)  en = 1'b0;
            if (off == 24) en = 1'b1;
            if (off == 26) tmit = 1'b0;
        end
        repeat (FL1) @(negedge pclk);
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, c;
        int nb;
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 5)) @(negedge pclk);
            a  = W'($urandom);
            b  = W'($urandom);
            c  = W'($urandom);
            nb = $urandom_range(1, 3);
            runStream(a, b, c, nb, 4, "random");
        end
    endtask

    task automatic test_reset_midframe();
        int n;
        bit ok;
        txdata = W'($urandom);
        tmit   = 1'b1;
        waitRemove(1'b0, n, ok);
        tmit = 1'b0;
        nChecks++;
        if (!ok) begin
            $display("[TB] FAIL midreset_start got=timeout expected=remove");
            nErrors++;
        end
        repeat (6) @(negedge pclk);
        clear = 1'b1;
        repeat (3) begin
            @(negedge pclk);
            nChecks++;
            if ({remove, sspfssout, ssptxd, sspoe_b, busy, sspclkout} !== 6'b000100) begin
                $display("[TB] FAIL midreset got=%b expected=000100",
                         {remove, sspfssout, ssptxd, sspoe_b, busy, sspclkout});
                nErrors++;
            end
        end
        clear = 1'b0;
        @(negedge pclk);
        nChecks++;
        if ({remove, sspfssout, sspoe_b, busy} !== 4'b0010) begin
            $display("[TB] FAIL after_midreset got=%b expected=0010", {remove, sspfssout, sspoe_b, busy});
            nErrors++;
        end
        repeat (4) @(negedge pclk);
    endtask

    task automatic test_divider();
        int n;
        bit ok;
        txdata3 = 8'hFF;
        tmit3   = 1'b1;
        waitRemove(1'b1, n, ok);
        nChecks++;
        if (!ok || n > 2 * HP3) begin
            $display("[TB] FAIL divider_latency got=%0d expected<=%0d", n, 2 * HP3);
            nErrors++;
            tmit3 = 1'b0;
            if (!ok) return;
        end
        checkFrame3(8'hFF, (W + 1) * 2 * HP3 + 6, "divider");
    endtask

    task automatic test_late_tmit();
        logic prev;
        logic [W-1:0] d;
        bit found;
        logic [1:0] expV, gotV;
        found = 1'b0;
        prev  = sspclkout3;
        for (int i = 0; i < 16 && !found; i++) begin
            @(negedge pclk);
            if (sspclkout3 && !prev) found = 1'b1;
            prev = sspclkout3;
        end
        nChecks++;
        if (!found) begin
            $display("[TB] FAIL late_rise got=timeout expected=rise");
            nErrors++;
            return;
        end
        @(negedge pclk);
        d       = W'($urandom);
        txdata3 = d;
        tmit3   = 1'b1;
        for (int k = 1; k < 2 * HP3; k++) begin
            @(negedge pclk);
            expV = (k == 2 * HP3 - 1) ? 2'b11 : 2'b00;
            gotV = {remove3, sspfssout3};
            nChecks++;
            if (gotV !== expV) begin
                $display("[TB] FAIL late_tmit k=%0d got=%b expected=%b", k, gotV, expV);
                nErrors++;
            end
        end
        checkFrame3(d, (W + 1) * 2 * HP3 + 4, "late_frame");
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_enable_gating();
        test_random();
        test_reset_midframe();
        test_divider();
        test_late_tmit();
        repeat (4) @(negedge pclk);
        nChecks++;
        if (expQ.size() != 0 || rxActive) begin
            $display("[TB] FAIL rx_drain got=%0d pending expected=0", expQ.size());
            nErrors++;
        end
        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule

// File: doc/ssp_tx_ctrl.md
Name: ssp_tx_ctrl

Overview:
Transmit sequencer for the SSP. It sits between the transmit FIFO and the SSP pins, and generates the serial clock. It pops one byte at a time from the FIFO using a one-cycle remove pulse, emits a one-period frame-sync, and then shifts the byte out MSB first. Frames run back-to-back while the FIFO reports data; otherwise the block idles with the output driver disabled.

Parameters:
DATA_W, 8, serial word width (bits per frame).
HALF_PERIOD, 1, number of pclk cycles per sspclkout half-period (must be >= 1).

Ports:
pclk  in  1  system clock; the only clock.
clear  in  1  reset. One clock; reset is synchronous and active-high.
en  in  1  transmit enable. Sampled only at a frame boundary.
tmit  in  1  FIFO has data; txdata is valid.
txdata  in  DATA_W  FIFO head word.
remove  out  1  one-pclk pop strobe to the FIFO.
sspclkout  out  1  serial clock, free-running.
sspfssout  out  1  frame sync, high for one sspclkout period before the MSB.
ssptxd  out  1  serial data.
sspoe_b  out  1  active-low output enable; low for the whole frame.
busy  out  1  high when state != IDLE.

Behaviour:
- Clock generator:
  - Counter wraps every HALF_PERIOD pclk cycles and toggles sspclkout on wrap.
  - Counter width is max(1, clog2(HALF_PERIOD)).
  - rise strobe = the pclk cycle in which sspclkout goes from 0 to 1.
  - All serial outputs update registered on rise, so they change on sspclkout rising edges. The receiver samples on falling edges.
- Reset (clear=1 at a pclk edge), overriding everything:
  - state=IDLE, counter=0, sspclkout=0, sspfssout=0, ssptxd=0, sspoe_b=1, remove=0, busy=0, shift register=0, bit count=0.
- Reset mid-frame: the frame is abandoned immediately. The popped byte is lost, with no retry. No remove pulse is issued while clear=1.
- State machine (transitions occur only on rise; all states hold otherwise):
  - IDLE: sspoe_b=1, sspfssout=0, ssptxd=0.
    - On rise with tmit=1 and en=1: load shift register from txdata, pulse remove for exactly one pclk in that same cycle, set sspfssout=1 and sspoe_b=0 → FRAME.
  - FRAME: on next rise: ssptxd=shift[DATA_W-1], sspfssout=0, bitcnt=DATA_W-1 → SHIFT.
  - SHIFT: on each rise with bitcnt>0: shift left, ssptxd=new MSB, bitcnt-1.
  - SHIFT, on rise with bitcnt==0 (last bit has had a full period):
    - If tmit=1 and en=1: reload, pulse remove, sspfssout=1, sspoe_b stays 0 → FRAME. This is back-to-back with no idle gap.
    - Otherwise: ssptxd=0, sspoe_b=1 → IDLE.
- Timing:
  - Frame length is DATA_W+1 sspclkout periods, i.e. (DATA_W+1)*2*HALF_PERIOD pclk cycles.
  - Latency from tmit rising in IDLE to sspfssout=1 is at most 2*HALF_PERIOD pclk cycles (the next rise).
- remove rules:
  - Asserted only when tmit=1.
  - Never asserted on two consecutive pclk cycles.
  - At most one pulse per frame.
- tmit changing between rises is ignored; only its value on the rise cycle matters.
- en deasserted mid-frame: the current frame completes, then the block goes to IDLE.
- busy is combinational from state. All other outputs are registered.

Decomposition:
- Package ssp_pkg holds:
  - state enum {IDLE, FRAME, SHIFT}, 2 bits.
  - default DATA_W.
  - helper constant for counter width.
- One sub-module: ssp_clk_gen (divider). Inputs pclk and clear; outputs sspclkout and rise; parameter HALF_PERIOD.

Test Plan:
- Reset: hold clear=1 for 3 cycles mid-frame → next cycle all outputs at reset values, no remove pulse, sspclkout=0.
- Single byte, HALF_PERIOD=1: tmit=1, txdata=8'hA5, then tmit=0 after remove →
  - exactly one remove pulse;
  - sspfssout high for 2 pclk;
  - ssptxd = 1,0,1,0,0,1,0,1, each held 2 pclk;
  - sspoe_b low for 18 pclk, then high; busy low afterwards.
- Back-to-back: FIFO supplies 8'h81 then 8'h7E →
  - two remove pulses 18 pclk apart;
  - second sspfssout follows the last bit of 8'h81 with no gap;
  - sspoe_b continuously low for 36 pclk.
- Divider: HALF_PERIOD=3, txdata=8'hFF → sspclkout period is 6 pclk; each bit is held 6 pclk; frame is 54 pclk.
- Enable gating: deassert en during bit 3 of 8'h3C with tmit still 1 → the frame completes, no further remove, block returns to IDLE. Reasserting en starts the next frame on the following rise.
- Late tmit: tmit rises 1 pclk after a rise while in IDLE → sspfssout rises on the next rise, not before; remove coincides with that rise.
